// File: rtl/mem_noc_arb_pkg.sv
// Shared types and helpers for the memory-side NoC arbiter.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

package mem_noc_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int unsigned DATA_W_DEF  = `NOC_DATA_WIDTH;
  localparam int unsigned LEN_LSB_DEF = 22;
  localparam int unsigned LEN_W_DEF   = 8;
  // Widest header the length extractor accepts; narrower flits are zero-extended.
  localparam int unsigned HDR_MAX_W   = 128;

  // Payload length (flits after the header) carried in a header flit.
  function automatic logic [31:0] get_len(input logic [HDR_MAX_W-1:0] hdr,
                                          input int unsigned lsb,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(hdr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/mem_noc_rr_pick.sv
// Two-way picker: boot traffic may take strict priority, otherwise
// round-robin on ties against the last granted requester.
module mem_noc_rr_pick (
  input  logic [1:0] val,
  input  logic       last_grant,
  input  logic       boot_prio,
  output logic [1:0] win
);

  // One-hot winner; zero when nobody is requesting
  always_comb begin
    win = 2'b00;
    if (boot_prio && val[1])  win = 2'b10;
    else if (val == 2'b11)    win = last_grant ? 2'b01 : 2'b10;
    else                      win = val;
  end

endmodule

// File: rtl/mem_noc_arbiter.sv
// Packet-atomic 2:1 flit arbiter feeding the memory-side async FIFO.
// Headers pass through combinationally; a multi-flit packet locks the
// output to its owner until the last flit. No flit storage.
module mem_noc_arbiter
  import mem_noc_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_LSB = LEN_LSB_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_prio,
  input  logic              in0_val,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_rdy,
  input  logic              in1_val,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_rdy,
  output logic              out_val,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic [1:0]        grant,
  output logic              busy
);

  arb_state_e       state, state_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic             owner, owner_nx;
  logic             last_grant, last_grant_nx;
  logic [1:0]       win, sel;
  logic             xfer;
  logic [LEN_W-1:0] hdr_len;

  mem_noc_rr_pick u_pick (
    .val        ({in1_val, in0_val}),
    .last_grant (last_grant),
    .boot_prio  (boot_prio),
    .win        (win)
  );

  // Length field of whatever flit is on the output; only used in IDLE
  assign hdr_len = LEN_W'(get_len(HDR_MAX_W'(out_data), LEN_LSB, LEN_W));

  // State register; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Next state: open a packet on a non-empty header, count body flits down
  always_comb begin
    state_nx      = state;
    rem_nx        = rem;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    if (xfer) begin
      if (state == IDLE) begin
        last_grant_nx = sel[1];
        if (hdr_len != '0) begin
          state_nx = BUSY;
          rem_nx   = hdr_len;
          owner_nx = sel[1];
        end
      end else begin
        rem_nx = rem - LEN_W'(1);
        if (rem == LEN_W'(1)) state_nx = IDLE;
      end
    end
  end

  // Outputs: route the owner (BUSY) or the live winner (IDLE); reset kills handshakes
  always_comb begin
    sel      = (state == BUSY) ? {owner, ~owner} : win;
    grant    = sel;
    busy     = (state == BUSY);
    out_val  = rst_n & |(sel & {in1_val, in0_val});
    out_data = sel[1] ? in1_data : (sel[0] ? in0_data : '0);
    in0_rdy  = rst_n & sel[0] & out_rdy;
    in1_rdy  = rst_n & sel[1] & out_rdy;
    xfer     = out_val & out_rdy;
  end

endmodule

// File: tb/tb_mem_noc_arbiter.sv
// Directed bench for mem_noc_arbiter: queue-fed sources, a packet-level
// reference model checked every cycle, and literal per-scenario orderings.
module tb_mem_noc_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          boot_prio = 1'b0;
  logic          in0_val = 1'b0, in1_val = 1'b0, out_rdy = 1'b1;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_rdy, in1_rdy, out_val, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    grant;

  mem_noc_arbiter #(.DATA_W(DW), .LEN_LSB(22), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .boot_prio(boot_prio),
    .in0_val(in0_val), .in0_data(in0_data), .in0_rdy(in0_rdy),
    .in1_val(in1_val), .in1_data(in1_data), .in1_rdy(in1_rdy),
    .out_val(out_val), .out_data(out_data), .out_rdy(out_rdy),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [63:0] q0[$], q1[$], expq[$], log_d[$];
  logic [1:0]  log_g[$];
  int          log_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Flit encoding: requester in [63:60], packet id in [59:48], len in [29:22], index low
  function automatic logic [63:0] mk(int r, int p, int idx, int len);
    return (64'(r) << 60) | (64'(p) << 48) | (64'(len) << 22) | 64'(idx);
  endfunction

  task automatic push_pkt(int r, int p, int len);
    for (int i = 0; i <= len; i++) begin
      if (r == 0) q0.push_back(mk(0, p, i, (i == 0) ? len : 0));
      else        q1.push_back(mk(1, p, i, (i == 0) ? len : 0));
    end
  endtask

  task automatic exp_pkt(int r, int p, int len);
    for (int i = 0; i <= len; i++) expq.push_back(mk(r, p, i, (i == 0) ? len : 0));
  endtask

  task automatic chk_seq(string name, int base);
    chk({name, "_count"}, 64'(log_d.size() - base), 64'(expq.size()));
    for (int i = 0; i < expq.size() && base + i < log_d.size(); i++)
      chk({name, "_flit"}, log_d[base + i], expq[i]);
    expq.delete();
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
      @(posedge clk); #2; n++;
    end
    chk({name, "_drain_in_time"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_count(string name, int target, int budget);
    int n = 0;
    while (log_d.size() < target && n < budget) begin
      @(posedge clk); n++;
    end
    chk({name, "_reached_count"}, 64'(n < budget), 64'd1);
  endtask

  // Sources: offer queue heads; pop after a handshake seen before the edge
  initial begin : drv
    logic f0, f1;
    forever begin
      @(negedge clk);
      f0 = in0_val && in0_rdy && rst_n;
      f1 = in1_val && in1_rdy && rst_n;
      @(posedge clk); #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      in0_val  = q0.size() > 0;
      in0_data = (q0.size() > 0) ? q0[0] : '0;
      in1_val  = q1.size() > 0;
      in1_data = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Reference model: packet owner + flits left, checked on every falling edge
  int m_owner = -1, m_left = 0, m_last = 1;
  always @(negedge clk) begin : model
    int es;
    logic ev;
    logic [1:0] v;
    logic [63:0] d[2];
    if (!rst_n) begin
      m_owner = -1; m_left = 0; m_last = 1;
      chk("rst_in0_rdy", 64'(in0_rdy), 64'd0);
      chk("rst_in1_rdy", 64'(in1_rdy), 64'd0);
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      v = {in1_val, in0_val};
      d[0] = in0_data; d[1] = in1_data;
      if (m_owner >= 0)                es = m_owner;
      else if (boot_prio && v[1])      es = 1;
      else if (v == 2'b11)             es = (m_last == 0) ? 1 : 0;
      else if (v[0])                   es = 0;
      else if (v[1])                   es = 1;
      else                             es = -1;
      ev = (es >= 0) ? v[es] : 1'b0;
      chk("grant",    64'(grant),    (es < 0) ? 64'd0 : 64'(1 << es));
      chk("busy",     64'(busy),     64'(m_owner >= 0));
      chk("out_val",  64'(out_val),  64'(ev));
      chk("out_data", out_data,      (es < 0) ? 64'd0 : d[es]);
      chk("in0_rdy",  64'(in0_rdy),  64'(es == 0 && out_rdy));
      chk("in1_rdy",  64'(in1_rdy),  64'(es == 1 && out_rdy));
      if (out_val && out_rdy) begin
        log_d.push_back(out_data); log_g.push_back(grant); log_c.push_back(cyc);
      end
      if (ev && out_rdy) begin
        if (m_owner < 0) begin
          m_last = es;
          if (((d[es] >> 22) & 64'd255) != 0) begin
            m_owner = es;
            m_left  = int'((d[es] >> 22) & 64'd255);
          end
        end else begin
          m_left--;
          if (m_left == 0) m_owner = -1;
        end
      end
    end
  end

  initial begin : main
    int b;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy",    64'(busy),    64'd0);
    chk("reset_in0_rdy", 64'(in0_rdy), 64'd0);
    chk("reset_out_val", 64'(out_val), 64'd0);
    chk("reset_grant",   64'(grant),   64'd0);

    // S1: both valid at reset release, len=2 each
    push_pkt(0, 1, 2); push_pkt(1, 1, 2);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    drain("s1", 100);
    exp_pkt(0, 1, 2); exp_pkt(1, 1, 2);
    chk_seq("s1", 0);
    if (log_g.size() >= 6) begin
      chk("s1_grant_first",  64'(log_g[0]), 64'd1);
      chk("s1_grant_third",  64'(log_g[2]), 64'd1);
      chk("s1_grant_fourth", 64'(log_g[3]), 64'd2);
      chk("s1_grant_sixth",  64'(log_g[5]), 64'd2);
      chk("s1_no_bubble",    64'(log_c[5] - log_c[0]), 64'd5);
    end

    // S2: zero-length header, then a tie goes to requester 1
    b = log_d.size();
    push_pkt(0, 2, 0);
    drain("s2a", 50);
    exp_pkt(0, 2, 0);
    chk_seq("s2a", b);
    b = log_d.size();
    push_pkt(0, 3, 0); push_pkt(1, 3, 0);
    drain("s2b", 50);
    exp_pkt(1, 3, 0); exp_pkt(0, 3, 0);
    chk_seq("s2b", b);

    // S3: boot priority, then raised mid-packet without preemption
    b = log_d.size();
    boot_prio = 1'b1;
    push_pkt(0, 4, 0); push_pkt(1, 4, 0);
    drain("s3a", 50);
    exp_pkt(1, 4, 0); exp_pkt(0, 4, 0);
    chk_seq("s3a", b);
    boot_prio = 1'b0;
    b = log_d.size();
    push_pkt(0, 5, 4);
    wait_count("s3b", b + 2, 50);
    #2;
    boot_prio = 1'b1;
    push_pkt(1, 5, 0);
    drain("s3b", 50);
    exp_pkt(0, 5, 4); exp_pkt(1, 5, 0);
    chk_seq("s3b", b);
    boot_prio = 1'b0;

    // S4: out_rdy toggling during a len=3 packet, requester 1 waiting
    b = log_d.size();
    push_pkt(0, 6, 3); push_pkt(1, 6, 0);
    begin
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 200) begin
        @(posedge clk); #2; out_rdy = ~out_rdy; n++;
      end
      chk("s4_drain_in_time", 64'(n < 200), 64'd1);
    end
    out_rdy = 1'b1;
    exp_pkt(0, 6, 3); exp_pkt(1, 6, 0);
    chk_seq("s4", b);
    if (log_c.size() >= b + 4) chk("s4_spacing", 64'(log_c[b + 3] - log_c[b]), 64'd6);

    // S5: reset after 2 of 5 flits
    @(posedge clk); #2;
    b = log_d.size();
    push_pkt(0, 7, 4);
    wait_count("s5", b + 2, 50);
    chk("s5_busy_before", 64'(busy), 64'd1);
    #3 rst_n = 1'b0;
    q0.delete();
    #1;
    chk("s5_async_in0_rdy", 64'(in0_rdy), 64'd0);
    chk("s5_async_in1_rdy", 64'(in1_rdy), 64'd0);
    chk("s5_async_out_val", 64'(out_val), 64'd0);
    chk("s5_async_busy",    64'(busy),    64'd0);
    push_pkt(1, 7, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drain("s5", 50);
    expq.push_back(mk(0, 7, 0, 4)); expq.push_back(mk(0, 7, 1, 0));
    exp_pkt(1, 7, 1);
    chk_seq("s5", b);
    if (log_g.size() >= b + 3) chk("s5_grant_after_reset", 64'(log_g[b + 2]), 64'd2);

    // S6: maximum length packet followed immediately by another header
    b = log_d.size();
    push_pkt(0, 8, 255); push_pkt(0, 9, 0);
    drain("s6", 400);
    exp_pkt(0, 8, 255); exp_pkt(0, 9, 0);
    chk_seq("s6", b);
    if (log_c.size() >= b + 257) chk("s6_no_bubble", 64'(log_c[b + 256] - log_c[b]), 64'd256);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
